// File: rtl/hash_word_streamer.sv
// Captures the squeezed SHAKE256 state on the rising edge of the squeezed flag and
// streams it out as WORD_W-bit words over a valid/ready port, MSW-first by default.
module hash_word_streamer #(
    parameter int DATA_W    = 1088,
    parameter int WORD_W    = 32,
    parameter bit MSW_FIRST = 1'b1,
    localparam int NWORDS   = DATA_W / WORD_W,
    localparam int IDX_W    = $clog2(NWORDS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              squeezed,
    input  logic [DATA_W-1:0] hash,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [IDX_W-1:0]  out_index,
    output logic              busy,
    output logic              overrun,
    output logic              state_dbg
);

    // Handshake: a word moves on a rising clock edge where out_valid && out_ready.
    // out_valid, out_index and out_data depend only on registers, so out_ready never
    // reaches out_valid combinationally and the word holds steady while stalled.

    localparam int BASE_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t              state;
    logic                squeezed_q;
    logic [DATA_W-1:0]   shadow;
    logic [BASE_W-1:0]   word_base;
    logic                sq_rise;
    logic                xfer;

    assign sq_rise   = squeezed & ~squeezed_q;
    assign xfer      = out_valid & out_ready;
    assign out_last  = (state == STREAM) && (out_index == LAST_IDX);
    assign state_dbg = state;

    // The shadow is cleared on reset, so the selected word also reads zero then.
    always_comb begin
        if (MSW_FIRST) begin
            word_base = BASE_W'((NWORDS - 1 - int'(out_index)) * WORD_W);
        end else begin
            word_base = BASE_W'(int'(out_index) * WORD_W);
        end
        out_data = shadow[word_base +: WORD_W];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            squeezed_q <= 1'b0;
            shadow     <= '0;
            out_index  <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            squeezed_q <= squeezed;
            case (state)
                IDLE: begin
                    if (sq_rise) begin
                        shadow    <= hash;
                        out_index <= '0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (xfer && out_last) begin
                        // A new hash arriving with the final handoff chains on without a gap.
                        out_index <= '0;
                        if (sq_rise) begin
                            shadow <= hash;
                        end else begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end else begin
                        if (sq_rise) begin
                            overrun <= 1'b1;
                        end
                        if (xfer) begin
                            out_index <= out_index + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    out_index <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_word_streamer.sv
// Directed bench for hash_word_streamer: full streams, stalls, held and repeated
// squeezed edges, back-to-back chaining and asynchronous reset mid-stream.
module tb_hash_word_streamer;

    localparam int DATA_W = 1088;
    localparam int WORD_W = 32;
    localparam int NWORDS = 34;
    localparam int IDX_W  = 6;
    localparam int CYCLES = 120;

    logic              clk;
    logic              rst;
    logic              squeezed;
    logic [DATA_W-1:0] hash_in;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [IDX_W-1:0]  out_index;
    logic              busy;
    logic              overrun;
    logic              state_dbg;

    logic [IDX_W+WORD_W-1:0] exp_q[$];
    int n_cmp;
    int n_err;

    hash_word_streamer dut (
        .clock     (clk),
        .reset     (rst),
        .squeezed  (squeezed),
        .hash      (hash_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_index (out_index),
        .busy      (busy),
        .overrun   (overrun),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] make_hash(input logic [31:0] base);
        logic [DATA_W-1:0] h;
        h = '0;
        for (int k = 0; k < NWORDS; k++) begin
            h[DATA_W-1-32*k -: 32] = base + 32'(k);
        end
        return h;
    endfunction

    task automatic push_words(input logic [31:0] base);
        for (int k = 0; k < NWORDS; k++) begin
            exp_q.push_back({IDX_W'(k), base + 32'(k)});
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_busy"},  64'(busy),      64'd0);
        check({tag, "_index"}, 64'(out_index), 64'd0);
        check({tag, "_last"},  64'(out_last),  64'd0);
    endtask

    // driver: present a hash and raise squeezed at a falling edge
    task automatic start_stream(input logic [31:0] base);
        @(negedge clk);
        hash_in   = make_hash(base);
        squeezed  = 1'b1;
        out_ready = 1'b1;
        push_words(base);
    endtask

    // Runs a fixed window, scoring every transfer against exp_q.
    task automatic collect(input int stall_idx, input int stall_len, input int hold_cycles,
                           input int rise_idx, input logic [31:0] rise_base, input bit rise_emits);
        logic [IDX_W+WORD_W-1:0] e;
        int  stalled;
        bit  rise_done;
        bit  chk_idle;
        bit  chk_cont;
        bit  drop_next;
        stalled   = 0;
        rise_done = 1'b0;
        chk_idle  = 1'b0;
        chk_cont  = 1'b0;
        drop_next = 1'b0;
        for (int cyc = 1; cyc <= CYCLES; cyc++) begin
            @(negedge clk);
            if (cyc >= hold_cycles || drop_next) squeezed = 1'b0;
            drop_next = 1'b0;
            if (chk_idle) begin
                check_idle_outputs("after_last");
                chk_idle = 1'b0;
            end
            if (chk_cont) begin
                check("chain_valid", 64'(out_valid), 64'd1);
                check("chain_index", 64'(out_index), 64'd0);
                chk_cont = 1'b0;
            end
            if (rise_idx >= 0 && !rise_done && out_valid && int'(out_index) == rise_idx) begin
                hash_in   = make_hash(rise_base);
                squeezed  = 1'b1;
                drop_next = 1'b1;
                rise_done = 1'b1;
                if (rise_emits) push_words(rise_base);
            end
            out_ready = 1'b1;
            if (stall_idx >= 0 && out_valid && int'(out_index) == stall_idx && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
                check("stall_data",  64'(out_data),  64'(exp_q[0][WORD_W-1:0]));
                check("stall_index", 64'(out_index), 64'(exp_q[0][IDX_W+WORD_W-1:WORD_W]));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_xfer", 64'(out_data), 64'hdead_beef);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_data",  64'(out_data),  64'(e[WORD_W-1:0]));
                    check("xfer_index", 64'(out_index), 64'(e[IDX_W+WORD_W-1:WORD_W]));
                    check("xfer_last",  64'(out_last),
                          64'(e[IDX_W+WORD_W-1:WORD_W] == IDX_W'(NWORDS - 1)));
                    if (e[IDX_W+WORD_W-1:WORD_W] == IDX_W'(NWORDS - 1)) begin
                        if (exp_q.size() == 0) chk_idle = 1'b1;
                        else chk_cont = 1'b1;
                    end
                end
            end
        end
        squeezed = 1'b0;
        check("lost_words", 64'(exp_q.size()), 64'd0);
        if (stall_idx >= 0) check("stall_cycles", 64'(stalled), 64'(stall_len));
    endtask

    initial begin
        bit reached;
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        squeezed  = 1'b0;
        hash_in   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_data",    64'(out_data),  64'd0);
        check("reset_overrun", 64'(overrun),   64'd0);
        check("reset_state",   64'(state_dbg), 64'd0);
        rst = 1'b0;

        // ready held high: 34 words, out_last only on the final one
        start_stream(32'hA500_0000);
        collect(-1, 0, 1, -1, 32'h0, 1'b0);

        // three-cycle stall at index 5
        start_stream(32'hA500_0000);
        collect(5, 3, 1, -1, 32'h0, 1'b0);

        // squeezed held high for 100 cycles yields one stream only
        start_stream(32'hB600_0000);
        collect(-1, 0, 100, -1, 32'h0, 1'b0);
        check("held_overrun", 64'(overrun), 64'd0);

        // second rise on the final transfer chains the new hash with no gap
        start_stream(32'hA500_0000);
        collect(-1, 0, 1, NWORDS - 1, 32'hC700_0000, 1'b1);
        check("chain_overrun", 64'(overrun), 64'd0);

        // second rise at index 10 is dropped and flagged
        start_stream(32'hA500_0000);
        collect(-1, 0, 1, 10, 32'hD800_0000, 1'b0);
        check("overrun_set", 64'(overrun), 64'd1);

        // asynchronous reset mid-stream, then a fresh stream
        start_stream(32'hE900_0000);
        @(negedge clk);
        squeezed = 1'b0;
        reached  = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            @(negedge clk);
            if (out_valid && out_index == IDX_W'(10)) reached = 1'b1;
        end
        check("reach_index10", 64'(reached), 64'd1);
        check("busy_mid", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        check("async_overrun", 64'(overrun), 64'd0);
        check("async_data",    64'(out_data), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        start_stream(32'h1234_0000);
        collect(-1, 0, 1, -1, 32'h0, 1'b0);
        check("post_reset_overrun", 64'(overrun), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
